sid_filter_seq: RTL and testbench

SID_FILTER_SEQ -- requirements
Module: sid_filter_seq

---
 rtl/sid_filter_seq.sv | 211 +++++++++++++++++++++
 tb/tb_sid_filter_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_seq.sv
// rtl/sid_filter_seq.sv - two-pass per-sample sequencer for a shared SID filter datapath
// Optional feature macro: SID_FILTER_DUAL_EN (defined: pass 1 serves chip 1; undefined: both passes serve chip 0)
module sid_filter_seq (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               clr_overrun,
  input  logic [15:0]        f0_0,
  input  logic [15:0]        f0_1,
  input  logic [7:0]         res_filt_0,
  input  logic [7:0]         res_filt_1,
  input  logic [7:0]         mode_vol_0,
  input  logic [7:0]         mode_vol_1,
  input  logic               mode_0,
  input  logic               mode_1,
  input  logic signed [21:0] v1_0,
  input  logic signed [21:0] v2_0,
  input  logic signed [21:0] v3_0,
  input  logic signed [21:0] ext_0,
  input  logic signed [21:0] v1_1,
  input  logic signed [21:0] v2_1,
  input  logic signed [21:0] v3_1,
  input  logic signed [21:0] ext_1,
  input  logic [17:0]        filt_audio,
  output logic [2:0]         state,
  output logic [15:0]        f0,
  output logic [7:0]         res_filt,
  output logic [7:0]         mode_vol,
  output logic               mode,
  output logic signed [21:0] voice1,
  output logic signed [21:0] voice2,
  output logic signed [21:0] voice3,
  output logic signed [21:0] ext_in,
  output logic [17:0]        audio0,
  output logic [17:0]        audio1,
  output logic               busy,
  output logic               sample_valid,
  output logic               overrun
);

  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_t;

  seq_t               seq_q, seq_d;
  logic [2:0]         step_q, step_d;
  logic               pass_q, pass_d;
  logic               sv_q, sv_d;
  logic               ovr_q, ovr_d;
  logic [17:0]        audio0_q, audio0_d;
  logic [17:0]        audio1_q, audio1_d;
  logic [15:0]        f0_q, f0_d;
  logic [7:0]         res_filt_q, res_filt_d;
  logic [7:0]         mode_vol_q, mode_vol_d;
  logic               mode_q, mode_d;
  logic signed [21:0] voice1_q, voice1_d;
  logic signed [21:0] voice2_q, voice2_d;
  logic signed [21:0] voice3_q, voice3_d;
  logic signed [21:0] ext_in_q, ext_in_d;
  logic               load_snap;
  logic               use_chip1;

`ifndef SID_FILTER_DUAL_EN
  // Chip-1 inputs are deliberately ignored in the single-chip build.
  logic unused_chip1;
  assign unused_chip1 = ^{f0_1, res_filt_1, mode_vol_1, mode_1, v1_1, v2_1, v3_1, ext_1};
`endif

  // Sequencer next state: 8-step passes issued strictly in pairs, captures and overrun tracking.
  always_comb begin
    seq_d     = seq_q;
    step_d    = step_q;
    pass_d    = pass_q;
    sv_d      = 1'b0;
    audio0_d  = audio0_q;
    audio1_d  = audio1_q;
    load_snap = 1'b0;
    case (seq_q)
      SEQ_IDLE: begin
        if (tick) begin
          seq_d     = SEQ_RUN;
          step_d    = 3'd0;
          pass_d    = 1'b0;
          load_snap = 1'b1;
        end
      end
      SEQ_RUN: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd6) begin
          if (pass_q) begin
            audio1_d = filt_audio;
            sv_d     = 1'b1;
          end else begin
            audio0_d = filt_audio;
          end
        end
        if (step_q == 3'd7) begin
          if (!pass_q) begin
            // Second pass follows immediately so the datapath's per-chip state swap stays paired.
            pass_d    = 1'b1;
            load_snap = 1'b1;
          end else begin
            seq_d  = SEQ_IDLE;
            pass_d = 1'b0;
            step_d = 3'd7;
          end
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  // Overrun is sticky; a tick arriving while busy beats a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (tick && (seq_q == SEQ_RUN)) ovr_d = 1'b1;
  end

  // Snapshot of the serviced chip's registers, taken only on entry to step 0 of a pass.
  always_comb begin
`ifdef SID_FILTER_DUAL_EN
    use_chip1 = pass_d;
`else
    use_chip1 = 1'b0;
`endif
    f0_d       = f0_q;
    res_filt_d = res_filt_q;
    mode_vol_d = mode_vol_q;
    mode_d     = mode_q;
    voice1_d   = voice1_q;
    voice2_d   = voice2_q;
    voice3_d   = voice3_q;
    ext_in_d   = ext_in_q;
    if (load_snap) begin
`ifdef SID_FILTER_DUAL_EN
      if (use_chip1) begin
        f0_d       = f0_1;
        res_filt_d = res_filt_1;
        mode_vol_d = mode_vol_1;
        mode_d     = mode_1;
        voice1_d   = v1_1;
        voice2_d   = v2_1;
        voice3_d   = v3_1;
        ext_in_d   = ext_1;
      end else
`endif
      begin
        f0_d       = f0_0;
        res_filt_d = res_filt_0;
        mode_vol_d = mode_vol_0;
        mode_d     = mode_0;
        voice1_d   = v1_0;
        voice2_d   = v2_0;
        voice3_d   = v3_0;
        ext_in_d   = ext_0;
      end
    end
  end

  // State register; reset returns to idle with the datapath on its no-op step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q      <= SEQ_IDLE;
      step_q     <= 3'd7;
      pass_q     <= 1'b0;
      sv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      audio0_q   <= '0;
      audio1_q   <= '0;
      f0_q       <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
      mode_q     <= 1'b0;
      voice1_q   <= '0;
      voice2_q   <= '0;
      voice3_q   <= '0;
      ext_in_q   <= '0;
    end else begin
      seq_q      <= seq_d;
      step_q     <= step_d;
      pass_q     <= pass_d;
      sv_q       <= sv_d;
      ovr_q      <= ovr_d;
      audio0_q   <= audio0_d;
      audio1_q   <= audio1_d;
      f0_q       <= f0_d;
      res_filt_q <= res_filt_d;
      mode_vol_q <= mode_vol_d;
      mode_q     <= mode_d;
      voice1_q   <= voice1_d;
      voice2_q   <= voice2_d;
      voice3_q   <= voice3_d;
      ext_in_q   <= ext_in_d;
    end
  end

  assign state        = step_q;
  assign busy         = (seq_q == SEQ_RUN);
  assign sample_valid = sv_q;
  assign overrun      = ovr_q;
  assign audio0       = audio0_q;
  assign audio1       = audio1_q;
  assign f0           = f0_q;
  assign res_filt     = res_filt_q;
  assign mode_vol     = mode_vol_q;
  assign mode         = mode_q;
  assign voice1       = voice1_q;
  assign voice2       = voice2_q;
  assign voice3       = voice3_q;
  assign ext_in       = ext_in_q;

endmodule

// File: tb/tb_sid_filter_seq.sv
// tb/tb_sid_filter_seq.sv - self-checking bench for sid_filter_seq
module tb_sid_filter_seq;

  logic               clk = 1'b0;
  logic               reset, tick, clr_overrun;
  logic [15:0]        f0_0, f0_1;
  logic [7:0]         res_filt_0, res_filt_1, mode_vol_0, mode_vol_1;
  logic               mode_0, mode_1;
  logic signed [21:0] v1_0, v2_0, v3_0, ext_0, v1_1, v2_1, v3_1, ext_1;
  logic [17:0]        filt_audio;
  logic [2:0]         state;
  logic [15:0]        f0;
  logic [7:0]         res_filt, mode_vol;
  logic               mode;
  logic signed [21:0] voice1, voice2, voice3, ext_in;
  logic [17:0]        audio0, audio1;
  logic               busy, sample_valid, overrun;

  sid_filter_seq dut (
    .clk(clk), .reset(reset), .tick(tick), .clr_overrun(clr_overrun),
    .f0_0(f0_0), .f0_1(f0_1), .res_filt_0(res_filt_0), .res_filt_1(res_filt_1),
    .mode_vol_0(mode_vol_0), .mode_vol_1(mode_vol_1), .mode_0(mode_0), .mode_1(mode_1),
    .v1_0(v1_0), .v2_0(v2_0), .v3_0(v3_0), .ext_0(ext_0),
    .v1_1(v1_1), .v2_1(v2_1), .v3_1(v3_1), .ext_1(ext_1),
    .filt_audio(filt_audio), .state(state), .f0(f0), .res_filt(res_filt),
    .mode_vol(mode_vol), .mode(mode), .voice1(voice1), .voice2(voice2),
    .voice3(voice3), .ext_in(ext_in), .audio0(audio0), .audio1(audio1),
    .busy(busy), .sample_valid(sample_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

`ifdef SID_FILTER_DUAL_EN
  localparam bit DUAL = 1'b1;
  localparam logic [15:0] P1_F0 = 16'h5678;
`else
  localparam bit DUAL = 1'b0;
  localparam logic [15:0] P1_F0 = 16'hBEEF;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the 16-cycle sample window, plus captured values.
  bit           m_active;
  int           m_off;
  logic [120:0] m_snap;
  logic [17:0]  m_a0, m_a1;
  logic         m_ov;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [120:0] pack_chip(input bit c);
    if (c) return {f0_1, res_filt_1, mode_vol_1, mode_1, v1_1, v2_1, v3_1, ext_1};
    return {f0_0, res_filt_0, mode_vol_0, mode_0, v1_0, v2_0, v3_0, ext_0};
  endfunction

  task automatic model_reset();
    m_active = 0; m_off = 0; m_snap = '0; m_a0 = '0; m_a1 = '0; m_ov = 0;
  endtask

  task automatic check_model();
    logic [2:0] es;
    logic eb, esv;
    if (m_active) begin
      es = 3'((m_off - 1) % 8); eb = 1'b1; esv = (m_off == 16);
    end else begin
      es = 3'd7; eb = 1'b0; esv = 1'b0;
    end
    chk("m_state", state, es);
    chk("m_busy", busy, eb);
    chk("m_sample_valid", sample_valid, esv);
    chk("m_overrun", overrun, m_ov);
    chk("m_audio0", audio0, m_a0);
    chk("m_audio1", audio1, m_a1);
    chk("m_snapshot", {f0, res_filt, mode_vol, mode, voice1, voice2, voice3, ext_in}, m_snap);
  endtask

  task automatic model_update();
    if (tick && m_active) m_ov = 1'b1;
    else if (clr_overrun) m_ov = 1'b0;
    if (!m_active) begin
      if (tick) begin
        m_active = 1; m_off = 1; m_snap = pack_chip(1'b0);
      end
    end else begin
      if (m_off == 7)  m_a0 = filt_audio;
      if (m_off == 15) m_a1 = filt_audio;
      if (m_off == 8)  m_snap = pack_chip(DUAL);
      if (m_off == 16) m_active = 0;
      else m_off++;
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs for the coming rising edge.
  task automatic step(input logic t, input logic c, input logic [17:0] fa);
    check_model();
    tick = t; clr_overrun = c; filt_audio = fa;
    model_update();
    @(negedge clk);
  endtask

  task automatic randomize_chips();
    f0_0 = 16'($urandom); f0_1 = 16'($urandom);
    res_filt_0 = 8'($urandom); res_filt_1 = 8'($urandom);
    mode_vol_0 = 8'($urandom); mode_vol_1 = 8'($urandom);
    mode_0 = 1'($urandom); mode_1 = 1'($urandom);
    v1_0 = 22'($urandom); v2_0 = 22'($urandom); v3_0 = 22'($urandom); ext_0 = 22'($urandom);
    v1_1 = 22'($urandom); v2_1 = 22'($urandom); v3_1 = 22'($urandom); ext_1 = 22'($urandom);
  endtask

  task automatic do_reset();
    tick = 0; clr_overrun = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        tick;
    logic        clr;
    logic [15:0] f0_0;
    logic [17:0] filt;
    logic [2:0]  st;
    logic        busy;
    logic        sv;
    logic        ov;
    logic [15:0] f0;
    logic [17:0] a0;
    logic [17:0] a1;
  } vec_t;

  vec_t tbl[19];
  int   sv_cnt;

  initial begin
    // Row i describes cycle T+i; tick at T, busy ticks at T+5 and T+16, clear at T+17.
    tbl[0]  = '{1'b1, 1'b0, 16'h1234, 18'h0,     3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 18'h0,     18'h0};
    tbl[1]  = '{1'b0, 1'b0, 16'h1234, 18'h0,     3'd0, 1'b1, 1'b0, 1'b0, 16'h1234, 18'h0,     18'h0};
    tbl[2]  = '{1'b0, 1'b0, 16'h1234, 18'h0,     3'd1, 1'b1, 1'b0, 1'b0, 16'h1234, 18'h0,     18'h0};
    tbl[3]  = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd2, 1'b1, 1'b0, 1'b0, 16'h1234, 18'h0,     18'h0};
    tbl[4]  = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd3, 1'b1, 1'b0, 1'b0, 16'h1234, 18'h0,     18'h0};
    tbl[5]  = '{1'b1, 1'b0, 16'hBEEF, 18'h0,     3'd4, 1'b1, 1'b0, 1'b0, 16'h1234, 18'h0,     18'h0};
    tbl[6]  = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd5, 1'b1, 1'b0, 1'b1, 16'h1234, 18'h0,     18'h0};
    tbl[7]  = '{1'b0, 1'b0, 16'hBEEF, 18'h00AAA, 3'd6, 1'b1, 1'b0, 1'b1, 16'h1234, 18'h0,     18'h0};
    tbl[8]  = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd7, 1'b1, 1'b0, 1'b1, 16'h1234, 18'h00AAA, 18'h0};
    tbl[9]  = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd0, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[10] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd1, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[11] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd2, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[12] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd3, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[13] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd4, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[14] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd5, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[15] = '{1'b0, 1'b0, 16'hBEEF, 18'h15555, 3'd6, 1'b1, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h0};
    tbl[16] = '{1'b1, 1'b0, 16'hBEEF, 18'h0,     3'd7, 1'b1, 1'b1, 1'b1, P1_F0,    18'h00AAA, 18'h15555};
    tbl[17] = '{1'b0, 1'b1, 16'hBEEF, 18'h0,     3'd7, 1'b0, 1'b0, 1'b1, P1_F0,    18'h00AAA, 18'h15555};
    tbl[18] = '{1'b0, 1'b0, 16'hBEEF, 18'h0,     3'd7, 1'b0, 1'b0, 1'b0, P1_F0,    18'h00AAA, 18'h15555};

    reset = 1'b1; tick = 0; clr_overrun = 0; filt_audio = '0;
    randomize_chips();
    f0_0 = 16'h1234; f0_1 = 16'h5678;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", state, 3'd7);
    chk("reset_busy", busy, 1'b0);
    chk("reset_audio", {audio0, audio1}, 36'h0);
    chk("reset_snapshot", {f0, res_filt, mode_vol, mode, voice1, voice2, voice3, ext_in}, 121'h0);
    reset = 1'b0;

    // Directed pair: state sequence, snapshots, captures, overrun and clear.
    for (int i = 0; i < 19; i++) begin
      f0_0 = tbl[i].f0_0;
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_sample_valid", sample_valid, tbl[i].sv);
      chk("tbl_overrun", overrun, tbl[i].ov);
      chk("tbl_f0", f0, tbl[i].f0);
      chk("tbl_audio0", audio0, tbl[i].a0);
      chk("tbl_audio1", audio1, tbl[i].a1);
      step(tbl[i].tick, tbl[i].clr, tbl[i].filt);
    end

    // Busy tick coinciding with clear: set wins; a later clear alone clears.
    step(1, 0, 18'h0);
    step(0, 0, 18'h0);
    step(1, 0, 18'h0);
    chk("ov_busy_tick", overrun, 1'b1);
    step(1, 1, 18'h0);
    chk("ov_set_beats_clr", overrun, 1'b1);
    step(0, 1, 18'h0);
    chk("ov_cleared", overrun, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 0, 18'h0);
    chk("pair_done_idle", busy, 1'b0);

    // Reset at T+10 aborts pass 1: no audio1 capture, no sample_valid afterwards.
    step(1, 0, 18'h0);
    for (int i = 1; i <= 9; i++) step(0, 0, (i == 7) ? 18'h2468A : 18'h0);
    chk("pre_reset_state", state, 3'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("abort_state", state, 3'd7);
    chk("abort_busy", busy, 1'b0);
    chk("abort_audio1", audio1, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    sv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (sample_valid) sv_cnt++;
      step(0, 0, 18'h3FFFF);
    end
    chk("abort_no_sample_valid", sv_cnt, 0);
    sv_cnt = 0;
    step(1, 0, 18'h0);
    for (int i = 0; i < 18; i++) begin
      if (sample_valid) sv_cnt++;
      step(0, 0, 18'($urandom));
    end
    chk("post_abort_pair_sv_once", sv_cnt, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      randomize_chips();
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0), 18'($urandom));
    end
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
